// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: mono 16-bit sample to I2S stereo stream with BCLK divider,
// one-deep holding register and underrun repeat of the last sample.
module audio_dac_serializer #(
  parameter int BCLK_HALF = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        frame_start,
  output logic        underrun
);
  logic [7:0]  div;
  logic [4:0]  bit_cnt, nxt;
  logic [31:0] frame;
  logic [15:0] hold, last_sample;
  logic        hold_full, wrap, fall, load;
  always_comb begin
    wrap = div == 8'(BCLK_HALF - 1);
    fall = wrap & AUD_BCLK;
    nxt  = bit_cnt + 5'd1;
    load = fall & (nxt == 5'd0);
  end
  assign sample_ready = !hold_full;
  // 5'd0 - nxt yields index 32-k, and 0 at k=0 picks the outgoing frame's LSB
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      div         <= '0;
      bit_cnt     <= 5'd31;
      frame       <= '0;
      hold        <= '0;
      last_sample <= '0;
      hold_full   <= 1'b0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b1;
      AUD_DACDAT  <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      div         <= wrap ? '0 : div + 8'd1;
      frame_start <= load;
      underrun    <= load & !hold_full;
      if (wrap) AUD_BCLK <= !AUD_BCLK;
      if (fall) begin
        bit_cnt     <= nxt;
        AUD_DACLRCK <= nxt[4];
        AUD_DACDAT  <= frame[5'd0 - nxt];
      end
      if (load) frame <= hold_full ? {hold, hold} : {last_sample, last_sample};
      if (load && hold_full) begin
        last_sample <= hold;
        hold_full   <= 1'b0;
      end else if (sample_valid && !hold_full) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: randomized and directed stimulus against a sample-level
// I2S reference model; a second instance checks frame timing at BCLK_HALF=16.
module tb_audio_dac_serializer;
  localparam int H = 2;
  logic        Clk = 1'b0, Reset = 1'b0, rst16 = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, underrun;
  logic        rdy16, bclk16, lrck16, dat16, fs16, ur16;
  int          n_cmp = 0, n_bad = 0;
  int          t, k = 31;
  logic        m_full, m_acc;
  logic [15:0] m_hold, m_last, m_shown, val;
  logic        e_bclk, e_lrck, e_dat, e_fs, e_ur;
  int          c16 = 0, first16 = -1, prev16 = -1, per16 = 0, n16 = 0;

  audio_dac_serializer #(.BCLK_HALF(H)) dut (
    .Clk(Clk), .Reset(Reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT), .frame_start(frame_start), .underrun(underrun)
  );

  audio_dac_serializer #(.BCLK_HALF(16)) dut16 (
    .Clk(Clk), .Reset(rst16), .sample_in(16'h0), .sample_valid(1'b0),
    .sample_ready(rdy16), .AUD_BCLK(bclk16), .AUD_DACLRCK(lrck16),
    .AUD_DACDAT(dat16), .frame_start(fs16), .underrun(ur16)
  );

  always #5 Clk = ~Clk;

  // c16 before increment equals the index of the edge that raised fs16
  always @(posedge Clk)
    if (rst16) begin
      c16 <= c16 + 1;
      if (fs16) begin
        if (first16 < 0) first16 <= c16;
        if (prev16 >= 0) per16 <= c16 - prev16;
        prev16 <= c16;
        n16    <= n16 + 1;
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; k = 31;
    m_full = 1'b0; m_acc = 1'b0;
    m_hold = '0; m_last = '0; m_shown = '0;
    e_bclk = 1'b0; e_lrck = 1'b1; e_dat = 1'b0; e_fs = 1'b0; e_ur = 1'b0;
  endtask

  task automatic check_outputs();
    chk("bclk", AUD_BCLK, e_bclk);
    chk("lrck", AUD_DACLRCK, e_lrck);
    chk("dat", AUD_DACDAT, e_dat);
    chk("frame_start", frame_start, e_fs);
    chk("underrun", underrun, e_ur);
    chk("ready", sample_ready, !m_full);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_bclk"}, AUD_BCLK, 1'b0);
    chk({tag, "_lrck"}, AUD_DACLRCK, 1'b1);
    chk({tag, "_dat"}, AUD_DACDAT, 1'b0);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_ur"}, underrun, 1'b0);
    chk({tag, "_ready"}, sample_ready, 1'b1);
  endtask

  // Time t counts clock edges since reset release; bit slot k = t/(2H)-1 mod 32.
  task automatic step();
    @(posedge Clk);
    m_acc = sample_valid && !m_full;
    t++;
    e_bclk = ((t / H) % 2) == 1;
    k = (t / (2 * H) + 31) % 32;
    e_lrck = k >= 16;
    e_fs = 1'b0;
    e_ur = 1'b0;
    if (t % (2 * H) == 0) begin
      if (k == 0) begin
        e_dat = m_shown[0];
        e_fs = 1'b1;
        if (m_full) begin
          m_shown = m_hold; m_last = m_hold; m_full = 1'b0;
        end else begin
          m_shown = m_last; e_ur = 1'b1;
        end
      end else e_dat = m_shown[(32 - k) % 16];
    end
    if (m_acc) begin
      m_hold = sample_in; m_full = 1'b1;
    end
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0;
    #1 check_reset_vals(tag);
    repeat (2) @(negedge Clk);
    check_reset_vals({tag, "_hold"});
    Reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_vals("por");
    Reset = 1'b1;
    rst16 = 1'b1;
    repeat (2 * 64 * H + 8) step();
    do_reset("rst_idle");
    sample_in = 16'h8001; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (3 * 64 * H) step();
    val = 16'd1; sample_valid = 1'b1;
    repeat (5 * 64 * H) begin
      sample_in = val;
      step();
      if (m_acc) val++;
    end
    sample_in = 16'h1234;
    for (int i = 0; i < 3 * 64 * H && !m_acc; i++) step();
    sample_valid = 1'b0;
    chk("s4_accept", sample_ready, 1'b0);
    repeat (4 * 64 * H) step();
    repeat (10 * 64 * H) begin
      sample_valid = ($urandom % 100) < 3;
      sample_in = 16'($urandom);
      step();
    end
    sample_in = 16'hbeef; sample_valid = 1'b1;
    for (int i = 0; i < 6 * 64 * H && !(m_full && k == 20); i++) step();
    sample_valid = 1'b0;
    chk("s5_held", sample_ready, 1'b0);
    do_reset("rst_mid");
    repeat (2 * 64 * H + 8) step();
    chk("h16_first", 32'(first16), 32'd32);
    chk("h16_period", 32'(per16), 32'd1024);
    chk("h16_frames", 32'(n16 >= 2), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
